// File: rtl/jk_sync_down_counter_pkg.sv
// Shared types and constants for the JK-based synchronous down-counter.
package jk_sync_down_counter_pkg;

    // Counter control state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Operating modes selected by the MODE parameter
    localparam int MODE_WRAP    = 0;
    localparam int MODE_ONESHOT = 1;
    localparam int MODE_RELOAD  = 2;

endpackage

// File: rtl/jk_sync_down_counter_jk_ff.sv
// Single JK flip-flop stage with synchronous active-high reset.
module jk_ff_sync (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    // JK behaviour: 00 hold, 01 clear, 10 set, 11 toggle
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_sync_down_counter.sv
// Loadable synchronous down-counter built from JK stages.
// All stages share clk, so there is no ripple skew between bits.
//
// state   | meaning
// --------+-----------------------------------------------------
// IDLE    | not armed; en only starts counting in wrap mode
// RUN     | armed, decrements on each en cycle (busy=1)
// DONE    | one-shot finished at 0; only load or rst leave it
module jk_sync_down_counter
    import jk_sync_down_counter_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int MODE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] reload;
    logic             tc_nxt;
    logic             do_dec;
    logic             do_ld;
    logic [WIDTH-1:0] ld_data;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;

    // Next-state, tc and the action (load / decrement / hold) for this edge
    always_comb begin
        state_nxt = state;
        tc_nxt    = 1'b0;
        do_dec    = 1'b0;
        do_ld     = 1'b0;
        ld_data   = load_val;
        if (load) begin
            do_ld   = 1'b1;
            ld_data = load_val;
            if (load_val != '0)
                state_nxt = ST_RUN;
            else if (MODE == MODE_ONESHOT)
                state_nxt = ST_DONE;
            else
                state_nxt = ST_IDLE;
        end else if (en) begin
            case (state)
                ST_IDLE: begin
                    // wrap mode starts on en alone; decrement from 0 wraps to all-ones
                    if (MODE == MODE_WRAP) begin
                        do_dec    = 1'b1;
                        state_nxt = ST_RUN;
                        tc_nxt    = (q == ONE);
                    end
                end
                ST_RUN: begin
                    if (q != '0) begin
                        do_dec = 1'b1;
                        if (q == ONE) begin
                            tc_nxt = 1'b1;
                            if (MODE == MODE_ONESHOT)
                                state_nxt = ST_DONE;
                        end
                    end else if (MODE == MODE_WRAP) begin
                        do_dec = 1'b1;
                    end else if (MODE == MODE_RELOAD) begin
                        // reload of 0 keeps q at 0 with no further tc
                        do_ld   = 1'b1;
                        ld_data = reload;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Reload register captures every explicit load
    always_ff @(posedge clk) begin
        if (rst)
            reload <= '0;
        else if (load)
            reload <= load_val;
    end

    // Registered terminal-count pulse, lines up with q first reading 0
    always_ff @(posedge clk) begin
        if (rst)
            tc <= 1'b0;
        else
            tc <= tc_nxt;
    end

    // Per-stage J/K steering: load uses J=d,K=~d; decrement toggles when all lower bits are 0
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        logic low_zero;
        if (i == 0) begin : g_lsb
            assign low_zero = 1'b1;
        end else begin : g_upper
            assign low_zero = ~|q[i-1:0];
        end
        assign j_vec[i] = do_ld ? ld_data[i]  : (do_dec & low_zero);
        assign k_vec[i] = do_ld ? ~ld_data[i] : (do_dec & low_zero);

        jk_ff_sync u_ff (
            .clk (clk),
            .rst (rst),
            .j   (j_vec[i]),
            .k   (k_vec[i]),
            .q   (q[i])
        );
    end

    assign busy = (state == ST_RUN);
    assign zero = (q == '0);

endmodule

// File: tb/tb_jk_sync_down_counter.sv
// Scoreboard bench: one instance per MODE, shared stimulus, arithmetic reference model.
module tb_jk_sync_down_counter;

    localparam int W   = 3;
    localparam int MAXV = (1 << W) - 1;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;

    logic [W-1:0] q0, q1, q2;
    logic         tc0, tc1, tc2;
    logic         busy0, busy1, busy2;
    logic         zero0, zero1, zero2;

    typedef struct packed {
        logic [2:0][W-1:0] q;
        logic [2:0]        tc;
        logic [2:0]        busy;
        logic [2:0]        zero;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_err    = 0;

    int m_q   [3];
    int m_rel [3];
    int m_st  [3];
    int m_tc  [3];

    always #5 clk = ~clk;

    jk_sync_down_counter #(.WIDTH(W), .MODE(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .q(q0), .tc(tc0), .busy(busy0), .zero(zero0));

    jk_sync_down_counter #(.WIDTH(W), .MODE(1)) u_oneshot (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .q(q1), .tc(tc1), .busy(busy1), .zero(zero1));

    jk_sync_down_counter #(.WIDTH(W), .MODE(2)) u_reload (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .q(q2), .tc(tc2), .busy(busy2), .zero(zero2));

    task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s mode=%0d t=%0t actual=%0h required=%0h", name, m, $time, act, req);
        end
    endtask

    // Behavioural model: counting described directly by the mode rules
    task automatic model_step(input int m, input bit r, input bit l, input bit e, input int lv);
        if (r) begin
            m_q[m] = 0; m_rel[m] = 0; m_st[m] = S_IDLE; m_tc[m] = 0;
            return;
        end
        m_tc[m] = 0;
        if (l) begin
            m_q[m]   = lv;
            m_rel[m] = lv;
            if (lv != 0)     m_st[m] = S_RUN;
            else if (m == 1) m_st[m] = S_DONE;
            else             m_st[m] = S_IDLE;
        end else if (e && (m_st[m] == S_RUN || (m_st[m] == S_IDLE && m == 0))) begin
            m_st[m] = S_RUN;
            if (m_q[m] > 0) begin
                m_q[m] = m_q[m] - 1;
                if (m_q[m] == 0) begin
                    m_tc[m] = 1;
                    if (m == 1) m_st[m] = S_DONE;
                end
            end else if (m == 0) begin
                m_q[m] = MAXV;
            end else if (m == 2) begin
                m_q[m] = m_rel[m];
            end else begin
                m_st[m] = S_DONE;
            end
        end
    endtask

    task automatic drive(input bit r, input bit l, input bit e, input int lv);
        exp_t x;
        @(negedge clk);
        rst = r; load = l; en = e; load_val = lv[W-1:0];
        for (int m = 0; m < 3; m++) begin
            model_step(m, r, l, e, lv);
            x.q[m]    = m_q[m][W-1:0];
            x.tc[m]   = (m_tc[m] != 0);
            x.busy[m] = (m_st[m] == S_RUN);
            x.zero[m] = (m_q[m] == 0);
        end
        sb.push_back(x);
    endtask

    task automatic run_en(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 1, 0);
    endtask

    // Monitor: every registered output update is compared against the queued expectation
    initial begin
        exp_t x;
        logic [2:0][W-1:0] aq;
        logic [2:0] atc, abusy, azero;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                aq    = {q2, q1, q0};
                atc   = {tc2, tc1, tc0};
                abusy = {busy2, busy1, busy0};
                azero = {zero2, zero1, zero0};
                for (int m = 0; m < 3; m++) begin
                    chk("q",    m, 32'(aq[m]),    32'(x.q[m]));
                    chk("tc",   m, 32'(atc[m]),   32'(x.tc[m]));
                    chk("busy", m, 32'(abusy[m]), 32'(x.busy[m]));
                    chk("zero", m, 32'(azero[m]), 32'(x.zero[m]));
                end
            end
        end
    end

    initial begin
        int pat [6];
        pat = '{1, 0, 1, 0, 1, 1};

        // free-run from reset, wraps through 0
        drive(1, 0, 0, 0);
        run_en(9);
        drive(0, 0, 1, 0);
        // one-shot style countdown, then en keeps asserting
        drive(0, 1, 1, 5);
        run_en(9);
        // reload-from-3 cycles
        drive(0, 1, 0, 3);
        run_en(8);
        // priority: load beats en, rst beats load
        drive(0, 1, 0, 4);
        run_en(2);
        drive(0, 1, 1, 6);
        drive(0, 0, 1, 0);
        drive(1, 1, 1, 5);
        drive(0, 0, 0, 0);
        // en gaps
        drive(0, 1, 0, 4);
        for (int i = 0; i < 6; i++) drive(0, 0, pat[i] != 0, 0);
        drive(0, 0, 0, 0);
        // reset mid-count
        drive(0, 1, 0, 7);
        run_en(3);
        drive(1, 0, 1, 0);
        run_en(2);
        // load of zero
        drive(0, 1, 0, 0);
        run_en(3);
        // reload of 1: tc every other cycle
        drive(0, 1, 0, 1);
        run_en(6);
        // reload of 0 while running
        drive(0, 1, 0, 1);
        drive(0, 1, 0, 0);
        run_en(3);
        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 2) != 0), int'($urandom_range(0, MAXV)));
        end
        drive(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
